hazard_sequencer: RTL and testbench
===================================

# hazard_sequencer

Pipeline control block for the 5-stage MIPS datapath, sitting beside the instruction decode phase. It detects load-use hazards and taken branches/jumps resolved in EX, and drives the PC, IF/ID and ID/EX control so the decode phase stalls, bubbles or flushes. It also sequences the multi-cycle HI/LO multiply/divide unit (MDU), holding dependent instructions in ID until the unit is free. A saturating stall counter is provided for performance measurement.

## Interface
- MDU_LATENCY, 4, cycles the MDU stays busy after its start cycle; legal range 1 and up.
- CNT_W, 16, width of stall_count.

- Clk  in  1  pipeline clock.
- Reset  in  1  asynchronous, active-low reset; one clock domain.
- id_valid  in  1  ID holds a real (non-bubble) instruction.
- id_rs, id_rt  in  5 each  source register fields in ID.
- id_uses_rs, id_uses_rt  in  1 each  the ID instruction actually reads rs/rt.
- id_is_mdu  in  1  ID holds mult/multu/div/divu.
- id_reads_hilo  in  1  ID holds mfhi/mflo.
- ex_MemRead  in  1  EX holds a load.
- ex_rt  in  5  load destination in EX.
- ex_branch_taken  in  1  branch/jump/jr resolved taken in EX.
- PCWrite  out  1  PC register enable.
- IFID_Write  out  1  IF/ID register enable.
- IFID_Flush  out  1  load NOP into IF/ID.
- IDEX_Bubble  out  1  zero all ID/EX control fields.
- mdu_start  out  1  one-cycle MDU launch pulse.
- mdu_busy  out  1  MDU occupied.
- stall_count  out  CNT_W  stall cycles since reset.

## Operation
- States: RUN, MDU_BUSY. Down-counter mdu_cnt.
- load_use = id_valid & ex_MemRead & (ex_rt != 0) & ((id_uses_rs & id_rs == ex_rt) | (id_uses_rt & id_rt == ex_rt)).
- mdu_dep = id_valid & (id_is_mdu | id_reads_hilo) & state == MDU_BUSY.
- stall = (load_use | mdu_dep) & ~ex_branch_taken.
- Priority 1, ex_branch_taken: IFID_Flush=1, IDEX_Bubble=1, PCWrite=1, IFID_Write=1. No stall is counted.
- Priority 2, stall: PCWrite=0, IFID_Write=0, IDEX_Bubble=1, IFID_Flush=0. stall_count increments and saturates at all-ones.
- Otherwise: PCWrite=1, IFID_Write=1, IFID_Flush=0, IDEX_Bubble=0.
- mdu_start = state==RUN & id_valid & id_is_mdu & ~stall & ~ex_branch_taken. On mdu_start: mdu_cnt <= MDU_LATENCY-1, state -> MDU_BUSY.
- In MDU_BUSY: mdu_busy=1. If mdu_cnt==0, state -> RUN; else mdu_cnt decrements. A taken branch does not cancel an issued MDU operation.
- Outputs are combinational from inputs and state. State, mdu_cnt and stall_count are registered on the rising edge of Clk.

## Timing
- Reset low, asynchronously: state RUN, mdu_cnt 0, stall_count 0, PCWrite=1, IFID_Write=1, IFID_Flush=0, IDEX_Bubble=0, mdu_start=0, mdu_busy=0. Hazard terms are masked while Reset is low.
- Load-use stall lasts exactly 1 cycle. The next cycle the load is in MEM and forwarding covers it.
- mdu_busy is high for exactly MDU_LATENCY cycles, beginning the cycle after mdu_start.
- A mult arriving in ID during the last busy cycle stalls 1 cycle, then starts, giving back-to-back occupancy.
- Reset asserted mid-MDU_BUSY: mdu_busy drops immediately and the pending operation is abandoned.
- A load-use hazard and a taken branch in the same cycle: the flush wins and stall_count is unchanged.

## Structure
- Shared package pipeline_ctrl_pkg holds: state enum (RUN, MDU_BUSY), REG_ZERO constant (5'd0), and the default MDU latency constant. The decode phase reuses the package.
- One natural sub-module, mdu_occupancy_counter: owns mdu_cnt and mdu_busy, takes mdu_start, and emits done.

## Test plan
- LW $1,0($0) in EX (ex_MemRead=1, ex_rt=1), ADD using rs=1 in ID -> 1 cycle of PCWrite=0, IFID_Write=0, IDEX_Bubble=1; stall_count=1; normal flow next cycle.
- Same as above with ex_rt=0, or id_uses_rs=0 -> no stall.
- ex_branch_taken=1 together with a load-use hazard -> IFID_Flush=1, IDEX_Bubble=1, PCWrite=1, stall_count unchanged.
- MDU_LATENCY=4: mult in ID -> 1-cycle mdu_start, then mdu_busy high for 4 cycles. mflo in ID during busy stalls until the cycle after busy falls; an ADD during busy proceeds with no stall.
- Reset pulled low on the 2nd busy cycle -> mdu_busy=0 and all outputs at reset values asynchronously; after release, a new mult starts normally.
- Force CNT_W=2 and drive 5 load-use stalls -> stall_count saturates at 3.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline-control definitions: MDU sequencing states, the
// hardwired zero register number and default sizing constants.
package pipeline_ctrl_pkg;

  // MDU occupancy as seen by the decode phase
  typedef enum logic {
    RUN      = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_t;

  // $zero never carries a real dependency
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Cycles the HI/LO unit stays occupied after its launch cycle
  localparam int MDU_LATENCY_DEFAULT = 4;

  // Default width of the stall performance counter
  localparam int STALL_CNT_W_DEFAULT = 16;

  // True when a source field is actually read and names the given register
  function automatic logic src_hits(input logic       uses,
                                    input logic [4:0] src,
                                    input logic [4:0] dst);
    return uses && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_sequencer_if.sv
// Decode-side control bundle: ID/EX hazard inputs and the PC, IF/ID,
// ID/EX and MDU control outputs of the hazard sequencer.
interface hazard_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_is_mdu;
  logic             id_reads_hilo;
  logic             ex_MemRead;
  logic [4:0]       ex_rt;
  logic             ex_branch_taken;

  logic             PCWrite;
  logic             IFID_Write;
  logic             IFID_Flush;
  logic             IDEX_Bubble;
  logic             mdu_start;
  logic             mdu_busy;
  logic [CNT_W-1:0] stall_count;

  // Pipeline side: presents decode/execute status, consumes control
  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_is_mdu, id_reads_hilo, ex_MemRead, ex_rt, ex_branch_taken,
    input  PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble,
           mdu_start, mdu_busy, stall_count
  );

  // Sequencer side
  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_is_mdu, id_reads_hilo, ex_MemRead, ex_rt, ex_branch_taken,
    output PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble,
           mdu_start, mdu_busy, stall_count
  );

endinterface

// File: rtl/mdu_occupancy_counter.sv
// Tracks how long the multi-cycle HI/LO unit remains occupied after a
// launch. busy_o is high for exactly MDU_LATENCY cycles starting the cycle
// after start_i; done_o marks the final busy cycle.
module mdu_occupancy_counter #(
  parameter int MDU_LATENCY = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic start_i,
  output logic busy_o,
  output logic done_o
);

  // Wide enough to hold MDU_LATENCY-1, never narrower than one bit
  localparam int CW = (MDU_LATENCY > 1) ? $clog2(MDU_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MDU_LATENCY - 1);

  logic [CW-1:0] mdu_cnt_q;
  logic          busy_q;

  // Load on launch, count down while occupied, release after reaching zero
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      mdu_cnt_q <= '0;
      busy_q    <= 1'b0;
    end else if (start_i) begin
      mdu_cnt_q <= CNT_LOAD;
      busy_q    <= 1'b1;
    end else if (busy_q) begin
      if (mdu_cnt_q == '0) begin
        busy_q <= 1'b0;
      end else begin
        mdu_cnt_q <= mdu_cnt_q - CW'(1);
      end
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && (mdu_cnt_q == '0);

endmodule

// File: rtl/hazard_sequencer.sv
// Decode-phase hazard control: load-use stalls, taken-branch flushes and
// HI/LO unit sequencing, plus a saturating stall-cycle counter.
module hazard_sequencer
  import pipeline_ctrl_pkg::*;
#(
  parameter int MDU_LATENCY = MDU_LATENCY_DEFAULT,
  parameter int CNT_W       = STALL_CNT_W_DEFAULT
) (
  input  logic               Clk,
  input  logic               Reset,
  hazard_sequencer_if.slave  bus
);

  mdu_state_t       state_q;
  logic [CNT_W-1:0] stall_count_q;
  logic [CNT_W-1:0] stall_count_d;

  logic load_use;
  logic mdu_dep;
  logic flush;
  logic stall;
  logic start;
  logic mdu_done;
  logic mdu_busy;

  mdu_occupancy_counter #(
    .MDU_LATENCY (MDU_LATENCY)
  ) u_mdu_cnt (
    .Clk     (Clk),
    .Reset   (Reset),
    .start_i (start),
    .busy_o  (mdu_busy),
    .done_o  (mdu_done)
  );

  // Hazard detection and priority: flush beats stall; everything is
  // masked while reset is held so the outputs sit at their idle values
  always_comb begin
    load_use = Reset && bus.id_valid && bus.ex_MemRead &&
               (bus.ex_rt != REG_ZERO) &&
               (src_hits(bus.id_uses_rs, bus.id_rs, bus.ex_rt) ||
                src_hits(bus.id_uses_rt, bus.id_rt, bus.ex_rt));
    mdu_dep  = Reset && bus.id_valid &&
               (bus.id_is_mdu || bus.id_reads_hilo) &&
               (state_q == MDU_BUSY);
    flush    = Reset && bus.ex_branch_taken;
    stall    = (load_use || mdu_dep) && !flush;
    start    = Reset && (state_q == RUN) && bus.id_valid && bus.id_is_mdu &&
               !stall && !flush;
  end

  assign bus.PCWrite     = !stall;
  assign bus.IFID_Write  = !stall;
  assign bus.IFID_Flush  = flush;
  assign bus.IDEX_Bubble = flush || stall;
  assign bus.mdu_start   = start;
  assign bus.mdu_busy    = mdu_busy;
  assign bus.stall_count = stall_count_q;

  // MDU sequencing: a launch occupies the unit until the counter finishes;
  // a taken branch does not cancel an operation already issued
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN:      if (start)    state_q <= MDU_BUSY;
        MDU_BUSY: if (mdu_done) state_q <= RUN;
        default:                state_q <= RUN;
      endcase
    end
  end

  // Stall counter next value, holding once all ones is reached
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && !(&stall_count_q)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  // Stall counter register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench: two sequencers (16-bit and 2-bit stall counters)
// share one stimulus stream and are compared every cycle against a
// behavioural model, with directed literal checks around it.
module tb_hazard_sequencer;

  localparam int LAT = 4;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = '0;
  logic [4:0] id_rt = '0;
  logic       id_uses_rs = 1'b0;
  logic       id_uses_rt = 1'b0;
  logic       id_is_mdu = 1'b0;
  logic       id_reads_hilo = 1'b0;
  logic       ex_MemRead = 1'b0;
  logic [4:0] ex_rt = '0;
  logic       ex_branch_taken = 1'b0;

  int tests = 0;
  int fails = 0;
  logic cmp_en = 1'b0;

  hazard_sequencer_if #(.CNT_W(16)) bus16 ();
  hazard_sequencer_if #(.CNT_W(2))  bus2 ();

  assign bus16.id_valid        = id_valid;
  assign bus16.id_rs           = id_rs;
  assign bus16.id_rt           = id_rt;
  assign bus16.id_uses_rs      = id_uses_rs;
  assign bus16.id_uses_rt      = id_uses_rt;
  assign bus16.id_is_mdu       = id_is_mdu;
  assign bus16.id_reads_hilo   = id_reads_hilo;
  assign bus16.ex_MemRead      = ex_MemRead;
  assign bus16.ex_rt           = ex_rt;
  assign bus16.ex_branch_taken = ex_branch_taken;

  assign bus2.id_valid         = id_valid;
  assign bus2.id_rs            = id_rs;
  assign bus2.id_rt            = id_rt;
  assign bus2.id_uses_rs       = id_uses_rs;
  assign bus2.id_uses_rt       = id_uses_rt;
  assign bus2.id_is_mdu        = id_is_mdu;
  assign bus2.id_reads_hilo    = id_reads_hilo;
  assign bus2.ex_MemRead       = ex_MemRead;
  assign bus2.ex_rt            = ex_rt;
  assign bus2.ex_branch_taken  = ex_branch_taken;

  hazard_sequencer #(.MDU_LATENCY(LAT), .CNT_W(16)) dut16 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus16.slave)
  );

  hazard_sequencer #(.MDU_LATENCY(LAT), .CNT_W(2)) dut2 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus2.slave)
  );

  always #5 Clk = ~Clk;

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic pcw;
    logic ifw;
    logic flush;
    logic bub;
    logic start;
    logic busy;
    logic stall;
  } exp_t;

  int busy_left = 0;   // remaining occupied cycles of the HI/LO unit
  int total     = 0;   // stall cycles counted since reset (unsaturated)

  function automatic exp_t predict();
    exp_t e;
    logic lu;
    logic dep;
    e = '0;
    e.pcw = 1'b1;
    e.ifw = 1'b1;
    if (!Reset) return e;
    lu  = id_valid && ex_MemRead && (ex_rt != 5'd0) &&
          ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
    dep = id_valid && (id_is_mdu || id_reads_hilo) && (busy_left > 0);
    if (ex_branch_taken) begin
      e.flush = 1'b1;
      e.bub   = 1'b1;
    end else if (lu || dep) begin
      e.pcw   = 1'b0;
      e.ifw   = 1'b0;
      e.bub   = 1'b1;
      e.stall = 1'b1;
    end
    e.start = (busy_left == 0) && id_valid && id_is_mdu && !e.stall && !ex_branch_taken;
    e.busy  = (busy_left > 0);
    return e;
  endfunction

  function automatic logic m_stall();
    exp_t e;
    e = predict();
    return e.stall;
  endfunction

  function automatic logic m_start();
    exp_t e;
    e = predict();
    return e.start;
  endfunction

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      busy_left <= 0;
      total     <= 0;
    end else begin
      total     <= total + (m_stall() ? 1 : 0);
      busy_left <= m_start() ? LAT : ((busy_left > 0) ? busy_left - 1 : 0);
    end
  end

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic compare_all();
    exp_t e;
    int s16;
    int s2;
    e   = predict();
    s16 = (total > 65535) ? 65535 : total;
    s2  = (total > 3) ? 3 : total;
    chk("cyc PCWrite16",     int'(bus16.PCWrite),     int'(e.pcw));
    chk("cyc IFID_Write16",  int'(bus16.IFID_Write),  int'(e.ifw));
    chk("cyc IFID_Flush16",  int'(bus16.IFID_Flush),  int'(e.flush));
    chk("cyc IDEX_Bubble16", int'(bus16.IDEX_Bubble), int'(e.bub));
    chk("cyc mdu_start16",   int'(bus16.mdu_start),   int'(e.start));
    chk("cyc mdu_busy16",    int'(bus16.mdu_busy),    int'(e.busy));
    chk("cyc stall_count16", int'(bus16.stall_count), s16);
    chk("cyc PCWrite2",      int'(bus2.PCWrite),      int'(e.pcw));
    chk("cyc IDEX_Bubble2",  int'(bus2.IDEX_Bubble),  int'(e.bub));
    chk("cyc IFID_Flush2",   int'(bus2.IFID_Flush),   int'(e.flush));
    chk("cyc mdu_start2",    int'(bus2.mdu_start),    int'(e.start));
    chk("cyc mdu_busy2",     int'(bus2.mdu_busy),     int'(e.busy));
    chk("cyc stall_count2",  int'(bus2.stall_count),  s2);
  endtask

  // Every-cycle comparison on the falling edge
  always @(negedge Clk) begin
    if (cmp_en) compare_all();
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    @(negedge Clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 1'b0; id_rs = '0; id_rt = '0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_is_mdu = 1'b0; id_reads_hilo = 1'b0;
    ex_MemRead = 1'b0; ex_rt = '0; ex_branch_taken = 1'b0;
  endtask

  task automatic load_use_add();
    clear_inputs();
    ex_MemRead = 1'b1; ex_rt = 5'd1;
    id_valid = 1'b1; id_rs = 5'd1; id_uses_rs = 1'b1; id_rt = 5'd2; id_uses_rt = 1'b1;
  endtask

  initial begin
    // Reset values while reset is held
    #2;
    chk("rst PCWrite",     int'(bus16.PCWrite), 1);
    chk("rst IFID_Write",  int'(bus16.IFID_Write), 1);
    chk("rst IFID_Flush",  int'(bus16.IFID_Flush), 0);
    chk("rst IDEX_Bubble", int'(bus16.IDEX_Bubble), 0);
    chk("rst mdu_start",   int'(bus16.mdu_start), 0);
    chk("rst mdu_busy",    int'(bus16.mdu_busy), 0);
    chk("rst stall_count", int'(bus16.stall_count), 0);
    $display("[TB] txn reset hold");
    #10 Reset = 1'b1;
    cmp_en = 1'b1;

    // Load-use: LW $1 in EX, ADD reading $1 in ID
    next_cycle();
    load_use_add();
    settle();
    chk("lu PCWrite",     int'(bus16.PCWrite), 0);
    chk("lu IFID_Write",  int'(bus16.IFID_Write), 0);
    chk("lu IDEX_Bubble", int'(bus16.IDEX_Bubble), 1);
    chk("lu IFID_Flush",  int'(bus16.IFID_Flush), 0);
    next_cycle();
    ex_MemRead = 1'b0; ex_rt = '0;
    settle();
    chk("lu after PCWrite", int'(bus16.PCWrite), 1);
    chk("lu after Bubble",  int'(bus16.IDEX_Bubble), 0);
    chk("lu count16",       int'(bus16.stall_count), 1);
    chk("lu model total",   total, 1);
    $display("[TB] txn load-use stall");

    // No stall when the load targets $zero, or the source is not read
    next_cycle();
    load_use_add();
    ex_rt = 5'd0; id_rs = 5'd0;
    settle();
    chk("zero PCWrite", int'(bus16.PCWrite), 1);
    next_cycle();
    load_use_add();
    id_uses_rs = 1'b0;
    settle();
    chk("unused PCWrite", int'(bus16.PCWrite), 1);
    chk("unused Bubble",  int'(bus16.IDEX_Bubble), 0);
    $display("[TB] txn non-hazards");

    // Taken branch together with a load-use hazard
    next_cycle();
    load_use_add();
    ex_branch_taken = 1'b1;
    settle();
    chk("br Flush",   int'(bus16.IFID_Flush), 1);
    chk("br Bubble",  int'(bus16.IDEX_Bubble), 1);
    chk("br PCWrite", int'(bus16.PCWrite), 1);
    chk("br IFID_Write", int'(bus16.IFID_Write), 1);
    next_cycle();
    clear_inputs();
    settle();
    chk("br count16", int'(bus16.stall_count), 1);
    $display("[TB] txn branch over load-use");

    // mult, then an independent ADD during the busy window
    next_cycle();
    id_valid = 1'b1; id_is_mdu = 1'b1;
    settle();
    chk("mult start", int'(bus16.mdu_start), 1);
    chk("mult busy0", int'(bus16.mdu_busy), 0);
    next_cycle();
    id_is_mdu = 1'b0; id_rs = 5'd3; id_uses_rs = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("add busy", int'(bus16.mdu_busy), (i < 4) ? 1 : 0);
      chk("add PCWrite", int'(bus16.PCWrite), 1);
      next_cycle();
    end
    $display("[TB] txn mult then add");

    // mult, then mflo held in ID until the unit frees up
    clear_inputs();
    id_valid = 1'b1; id_is_mdu = 1'b1;
    settle();
    chk("mult2 start", int'(bus16.mdu_start), 1);
    next_cycle();
    id_is_mdu = 1'b0; id_reads_hilo = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("mflo PCWrite", int'(bus16.PCWrite), (i == 4) ? 1 : 0);
      chk("mflo start", int'(bus16.mdu_start), 0);
      next_cycle();
    end
    clear_inputs();
    settle();
    chk("mflo count16", int'(bus16.stall_count), 5);
    chk("mflo count2 sat", int'(bus2.stall_count), 3);
    chk("mflo model total", total, 5);
    $display("[TB] txn mult then mflo");

    // Reset asserted on the second busy cycle
    next_cycle();
    id_valid = 1'b1; id_is_mdu = 1'b1;
    settle();
    chk("mult3 start", int'(bus16.mdu_start), 1);
    next_cycle();
    clear_inputs();
    settle();
    next_cycle();
    settle();
    chk("mid busy", int'(bus16.mdu_busy), 1);
    load_use_add();
    ex_branch_taken = 1'b1;
    #1 Reset = 1'b0;
    #1;
    chk("arst busy",    int'(bus16.mdu_busy), 0);
    chk("arst Flush",   int'(bus16.IFID_Flush), 0);
    chk("arst Bubble",  int'(bus16.IDEX_Bubble), 0);
    chk("arst PCWrite", int'(bus16.PCWrite), 1);
    chk("arst count",   int'(bus16.stall_count), 0);
    clear_inputs();
    Reset = 1'b1;
    next_cycle();
    id_valid = 1'b1; id_is_mdu = 1'b1;
    settle();
    chk("post start", int'(bus16.mdu_start), 1);
    chk("post busy0", int'(bus16.mdu_busy), 0);
    next_cycle();
    clear_inputs();
    settle();
    chk("post busy1", int'(bus16.mdu_busy), 1);
    $display("[TB] txn reset mid-busy");

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      id_valid        = ($urandom_range(0, 7) != 0);
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      id_uses_rs      = 1'($urandom_range(0, 1));
      id_uses_rt      = 1'($urandom_range(0, 1));
      id_is_mdu       = ($urandom_range(0, 5) == 0);
      id_reads_hilo   = ($urandom_range(0, 4) == 0);
      ex_MemRead      = ($urandom_range(0, 2) == 0);
      ex_rt           = 5'($urandom_range(0, 3));
      ex_branch_taken = ($urandom_range(0, 9) == 0);
      Reset           = ($urandom_range(0, 199) != 0);
    end
    next_cycle();
    Reset = 1'b1;
    clear_inputs();
    settle();
    $display("[TB] txn random traffic done");

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
